// File: rtl/move_input_conditioner.sv
// Button front end for the 2048 logic module: synchronizes, debounces and
// arbitrates the raw active-low buttons into single-cycle move/reset strobes,
// and latches the win-target switches on game reset.
module move_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LOCKOUT_CYCLES  = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_left_n,
  input  logic       btn_right_n,
  input  logic       btn_reset_n,
  input  logic [1:0] target_sel,
  output logic       up_state,
  output logic       down_state,
  output logic       left_state,
  output logic       right_state,
  output logic       reset_state,
  output logic       win_a,
  output logic       win_b,
  output logic       win_c,
  output logic       win_d,
  output logic       busy
);

  localparam int unsigned NB   = 5;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LO_W = $clog2(LOCKOUT_CYCLES + 1);

  // Button index order: 0 reset, 1 up, 2 down, 3 left, 4 right
  localparam int unsigned B_RESET = 0;
  localparam int unsigned B_UP    = 1;
  localparam int unsigned B_DOWN  = 2;
  localparam int unsigned B_LEFT  = 3;
  localparam int unsigned B_RIGHT = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_LOCKOUT,
    S_WAIT_RELEASE
  } state_t;

  typedef enum logic [2:0] {
    D_RESET,
    D_UP,
    D_DOWN,
    D_LEFT,
    D_RIGHT
  } dir_t;

  logic [NB-1:0]   btn_raw;
  logic [NB-1:0]   sync1_q, sync2_q;
  logic [NB-1:0]   pressed;
  logic [DB_W-1:0] db_cnt_q [NB];
  logic [DB_W-1:0] db_cnt_d [NB];
  logic [NB-1:0]   deb_q, deb_d;
  logic [NB-1:0]   deb_dly_q;
  logic [NB-1:0]   press_q, press_d;

  state_t          state_q, state_d;
  dir_t            dir_q, dir_d;
  logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
  logic            init_q, init_d;
  logic [3:0]      win_q, win_d_n;
  logic            pulse;

  assign btn_raw = {btn_right_n, btn_left_n, btn_down_n, btn_up_n, btn_reset_n};
  assign pressed = ~sync2_q;

  // Two-flop synchronizer on the raw levels; reset value is "released"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count cycles of disagreement, flip the level once it persists
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (pressed[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Press event is registered one cycle after the debounced rising edge
  always_comb begin
    press_d = deb_q & ~deb_dly_q;
  end

  // Debounce and press-event state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB; i++) begin
        db_cnt_q[i] <= '0;
      end
      deb_q     <= '0;
      deb_dly_q <= '0;
      press_q   <= '0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      press_q   <= press_d;
    end
  end

  // Arbitration FSM: priority pick in IDLE, reset press preempts the lockout
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    lo_cnt_d = lo_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|press_q) begin
          state_d = S_PULSE;
          if (press_q[B_RESET])      dir_d = D_RESET;
          else if (press_q[B_UP])    dir_d = D_UP;
          else if (press_q[B_DOWN])  dir_d = D_DOWN;
          else if (press_q[B_LEFT])  dir_d = D_LEFT;
          else                       dir_d = D_RIGHT;
        end
      end
      S_PULSE: begin
        lo_cnt_d = LO_W'(LOCKOUT_CYCLES - 1);
        state_d  = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (press_q[B_RESET]) begin
          dir_d   = D_RESET;
          state_d = S_PULSE;
        end else if (lo_cnt_q == '0) begin
          state_d = S_WAIT_RELEASE;
        end else begin
          lo_cnt_d = lo_cnt_q - LO_W'(1);
        end
      end
      S_WAIT_RELEASE: begin
        if (press_q[B_RESET]) begin
          dir_d   = D_RESET;
          state_d = S_PULSE;
        end else if (deb_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, latched direction and lockout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dir_q    <= D_RESET;
      lo_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end

  // Strobes decode straight from state so an async reset cuts them at once
  always_comb begin
    pulse       = (state_q == S_PULSE);
    reset_state = pulse && (dir_q == D_RESET);
    up_state    = pulse && (dir_q == D_UP);
    down_state  = pulse && (dir_q == D_DOWN);
    left_state  = pulse && (dir_q == D_LEFT);
    right_state = pulse && (dir_q == D_RIGHT);
    busy        = (state_q != S_IDLE);
  end

  // Win target loads on the first cycle out of reset and on each game reset
  always_comb begin
    init_d  = 1'b1;
    win_d_n = win_q;
    if (!init_q || reset_state) begin
      case (target_sel)
        2'b00:   win_d_n = 4'b0001;
        2'b01:   win_d_n = 4'b0010;
        2'b10:   win_d_n = 4'b0100;
        default: win_d_n = 4'b1000;
      endcase
    end
  end

  // Win target register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      win_q  <= 4'b0001;
    end else begin
      init_q <= init_d;
      win_q  <= win_d_n;
    end
  end

  assign win_a = win_q[0];
  assign win_b = win_q[1];
  assign win_c = win_q[2];
  assign win_d = win_q[3];

endmodule
